// File: rtl/dec_scan_sel.sv
// dec_scan_sel: registered SEL_W-to-2^SEL_W one-hot decoder with two modes.
//   direct (mode = 0): decodes a select code taken over a valid/ready handshake
//   scan   (mode = 1): steps through every output, SCAN_DIV cycles per index,
//                      and pulses wrap when the index returns to 0
// Build option: define DEC_ACTIVE_LOW_EN for a one-cold output.
// In that build the inactive pattern, including the reset value, is all ones.
module dec_scan_sel #(
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      sel_out,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] INACTIVE = '1;
`else
  localparam logic [OUT_W-1:0] INACTIVE = '0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;

  logic [SEL_W-1:0] nxt_idx;
  logic [DIV_W-1:0] nxt_div;
  logic             nxt_valid;
  logic             nxt_wrap;

  // Decode an index into the output polarity of this build.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] onehot;
    onehot    = '0;
    onehot[s] = 1'b1;
    return onehot ^ INACTIVE;
  endfunction

  // A code can be taken whenever the block is not scanning.
  assign in_ready = ~mode;

  // Next index, divider, valid and wrap values.
  // The output register decodes these, so out, sel_out and wrap stay aligned.
  always_comb begin
    // NOTE: every signal gets a default before the branches.
    // A path that leaves one unassigned would infer a latch.
    nxt_idx   = sel_out;
    nxt_div   = div;
    nxt_valid = out_valid;
    nxt_wrap  = 1'b0;
    if (mode) begin
      if (state != SCAN) begin
        nxt_idx   = '0;
        nxt_div   = '0;
        nxt_valid = 1'b1;
      end else if (div == DIV_LAST) begin
        nxt_div  = '0;
        nxt_idx  = SEL_W'(sel_out + 1'b1);
        nxt_wrap = (sel_out == IDX_LAST);
      end else begin
        nxt_div = DIV_W'(div + 1'b1);
      end
    end else if (in_valid) begin
      nxt_idx   = in_sel;
      nxt_div   = '0;
      nxt_valid = 1'b1;
    end else if (state == SCAN) begin
      nxt_div   = '0;
      nxt_valid = 1'b0;
    end
  end

  // State register and all registered outputs.
  // The en gate acts only on the out register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= '0;
      sel_out   <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      out       <= INACTIVE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments.
      // Every register then samples values from before the edge,
      // whatever order these statements are written in.
      if (mode)
        state <= SCAN;
      else if (in_valid)
        state <= HOLD;
      else if (state == SCAN)
        state <= IDLE;

      div       <= nxt_div;
      sel_out   <= nxt_idx;
      out_valid <= nxt_valid;
      wrap      <= nxt_wrap;
      out       <= (nxt_valid && en) ? decode(nxt_idx) : INACTIVE;
    end
  end

endmodule

// File: doc/dec_scan_sel.md
# dec_scan_sel

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes. Direct mode decodes a select code accepted over a valid/ready handshake. Scan mode auto-steps through all outputs at a programmable rate, for strobe/digit multiplexing. It sits between control logic and multiplexed loads (display digits, bank enables) and supersedes the fixed combinational 3-to-8 decoder.

## Interface
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam); legal 1..6
- SCAN_DIV, 4, clock cycles per scan step in scan mode; legal >= 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = direct, 1 = scan; sampled every cycle
- en  input  1  output gate; 0 forces out to the inactive pattern (next cycle)
- in_valid  input  1  select code offered (direct mode)
- in_ready  output  1  decoder accepts a code; combinational, equals ~mode
- in_sel  input  SEL_W  select code
- out  output  OUT_W  registered decoded output, one-hot (active-high by default)
- out_valid  output  1  out reflects a decoded index
- sel_out  output  SEL_W  index currently decoded on out
- wrap  output  1  one-cycle pulse when the scan index wraps OUT_W-1 -> 0

## Operation
- The FSM has 3 states: IDLE (direct, nothing accepted), HOLD (direct, index held), SCAN.
- Reset puts the FSM in IDLE with out = inactive pattern (all 0), out_valid = 0, sel_out = 0, wrap = 0, divider = 0.
- IDLE/HOLD: accept when in_valid & in_ready. Next state is HOLD, sel_out <= in_sel, out_valid <= 1.
- In HOLD, a new accept replaces the index. No accept leaves everything held.
- mode = 1 in any state moves to SCAN. Index and divider reset to 0, out_valid <= 1, and out decodes index 0 on the next edge.
- SCAN: the divider counts 0..SCAN_DIV-1. On a terminal count it clears and the index advances by 1 modulo OUT_W.
- Advance OUT_W-1 -> 0 asserts wrap for exactly that cycle (registered, aligned with out showing index 0).
- mode = 0 while in SCAN moves to IDLE: out <= inactive, out_valid <= 0, sel_out holds its last value. A simultaneous in_valid on the switch cycle is accepted because in_ready = ~mode.
- en = 0 drives out to the inactive pattern on the next edge. The FSM, index, divider, out_valid and wrap keep running. en returning to 1 restores decoding of the current index next edge.
- Out-of-range in_sel cannot occur, because the full SEL_W code space is decoded.
- With SCAN_DIV = 1 the index advances every cycle. The divider width is clog2(SCAN_DIV), minimum 1 bit.

## Timing
- Direct latency is 1 cycle: a code accepted at edge N appears on out/sel_out/out_valid after edge N.
- Scan entry: mode rises before edge N, index 0 appears after edge N, the first advance is after edge N+SCAN_DIV, and each index is held SCAN_DIV cycles.
- The full scan period is OUT_W*SCAN_DIV cycles. wrap pulses once per period.
- Asynchronous reset mid-scan or mid-hold clears all outputs immediately, independent of clk. Operation resumes on the first edge after rst_n deasserts.
- out, out_valid, sel_out and wrap are all registered outputs. in_ready is the only combinational output.

## Configuration
- DEC_ACTIVE_LOW_EN undefined: out is active-high one-hot. The inactive pattern (reset, en = 0, IDLE) is all zeros.
- DEC_ACTIVE_LOW_EN defined: out is one-cold (bitwise inverted). The inactive pattern is all ones, including the reset value.
- sel_out, out_valid, wrap and the handshake are identical in both builds.

## Test plan
- Reset and direct decode (SEL_W = 3): hold rst_n = 0, so out = 8'h00 and out_valid = 0. Release, accept in_sel = 5, and the next cycle gives out = 8'h20, sel_out = 5, out_valid = 1. Drop in_valid, and out holds 8'h20.
- Back-to-back accepts: in_sel = 0, 7, 3 on consecutive cycles produce out = 8'h01, 8'h80, 8'h08 on the three following cycles.
- Scan (SCAN_DIV = 4): mode = 1, and out steps 8'h01 (4 cycles), 8'h02, …, 8'h80. wrap is high only on the cycle out returns to 8'h01, and in_ready = 0 throughout.
- Gate and mode exit: in scan, pulse en = 0 for 3 cycles. out = 8'h00 for those cycles, and the index keeps advancing (resumes at the correct later index). Set mode = 0 with in_valid = 1, in_sel = 2, and the next cycle gives out = 8'h04.
- Mid-operation reset: assert rst_n = 0 asynchronously mid-scan, and out, wrap, out_valid and sel_out clear immediately. After release, the block is in IDLE with in_ready = 1.
- DEC_ACTIVE_LOW_EN build: reset gives out = 8'hFF, and accepting in_sel = 1 gives out = 8'hFD.
